// File: rtl/decodificador_pkg.sv
// rtl/decodificador_pkg.sv - shared FSM states, decoder state codes and symbol codes
package decodificador_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    APRESENTA,
    ESPERA,
    AVALIA,
    SUCESSO,
    FALHA,
    LIMPA
  } estado_e;

  localparam logic [3:0] OK_STATE  = 4'b1001;
  localparam logic [3:0] ERR_STATE = 4'b1000;

  localparam logic [6:0] C1 = 7'h11;
  localparam logic [6:0] C2 = 7'h22;
  localparam logic [6:0] C3 = 7'h33;
  localparam logic [6:0] C4 = 7'h44;
  localparam logic [6:0] C5 = 7'h55;
  localparam logic [6:0] C6 = 7'h66;

endpackage

// File: rtl/fifo_simbolos.sv
// rtl/fifo_simbolos.sv - symbol FIFO with flush; flush wins over push and pop
module fifo_simbolos #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = mem_q[rd_q];

  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = data_in;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sequenciador_decodificador.sv
// rtl/sequenciador_decodificador.sv - feeds buffered symbols to the sequence decoder and reports the verdict
module sequenciador_decodificador #(
  parameter int         DEPTH          = 4,
  parameter int         STEP_WAIT      = 2,
  parameter int         SEQ_LEN        = 4,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [3:0] OK_STATE       = decodificador_pkg::OK_STATE,
  parameter logic [3:0] ERR_STATE      = decodificador_pkg::ERR_STATE
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  input  logic [6:0]             in_data,
  output logic                   in_ready,
  output logic [6:0]             dec_entrada,
  output logic                   dec_controle,
  output logic                   dec_reset,
  input  logic [3:0]             dec_saida,
  output logic                   desbloqueado,
  output logic                   erro,
  output logic                   ocupado,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import decodificador_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = $clog2(SEQ_LEN + 1);
  localparam int WW = $clog2(STEP_WAIT + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(SEQ_LEN - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(STEP_WAIT - 1);

  estado_e       state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [SW-1:0] sym_q, sym_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [6:0]    entrada_q, entrada_d;
  logic          controle_q, controle_d;
  logic          dreset_q, dreset_d;
  logic          desbl_q, desbl_d;
  logic          erro_q, erro_d;
  logic          ativo_q;

  logic       fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [6:0] fifo_out;

  // ativo_q keeps the handshake and busy flag quiet until the first edge after reset
  assign in_ready   = ativo_q && !fifo_full && (state_q != FALHA);
  assign ocupado    = ativo_q && ((state_q != OCIOSO) || !fifo_empty);
  assign fifo_push  = in_valid && in_ready;
  assign fifo_pop   = (state_q == OCIOSO) && !fifo_empty;
  assign fifo_flush = (state_q == FALHA);
  assign tmo_inc    = tmo_q + TW'(1);

  assign dec_entrada  = entrada_q;
  assign dec_controle = controle_q;
  assign dec_reset    = dreset_q;
  assign desbloqueado = desbl_q;
  assign erro         = erro_q;

  fifo_simbolos #(
    .DEPTH(DEPTH),
    .WIDTH(7)
  ) u_fifo (
    .clk     (clk),
    .Reset   (Reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .data_in (in_data),
    .data_out(fifo_out),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= LIMPA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO: begin
        if (!fifo_empty) begin
          state_d = APRESENTA;
        end else if ((sym_q != '0) && (tmo_inc == TMO_LAST)) begin
          state_d = FALHA;
        end
      end
      APRESENTA: state_d = ESPERA;
      ESPERA:    if (wait_q == '0) state_d = AVALIA;
      AVALIA: begin
        if (dec_saida == OK_STATE) begin
          state_d = SUCESSO;
        end else if (dec_saida == ERR_STATE) begin
          state_d = FALHA;
        end else if (sym_q == SYM_LAST) begin
          state_d = FALHA;
        end else begin
          state_d = OCIOSO;
        end
      end
      SUCESSO:  state_d = LIMPA;
      FALHA:    state_d = LIMPA;
      LIMPA:    state_d = OCIOSO;
      default:  state_d = LIMPA;
    endcase
  end

  always_comb begin
    tmo_d      = tmo_q;
    sym_d      = sym_q;
    wait_d     = wait_q;
    entrada_d  = entrada_q;
    controle_d = 1'b0;
    dreset_d   = 1'b0;
    desbl_d    = 1'b0;
    erro_d     = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (!fifo_empty) begin
          entrada_d  = fifo_out;
          controle_d = 1'b1;
          tmo_d      = '0;
        end else if (sym_q != '0) begin
          tmo_d = tmo_inc;
        end
      end
      APRESENTA: wait_d = WAIT_LOAD;
      ESPERA:    if (wait_q != '0) wait_d = wait_q - WW'(1);
      AVALIA: begin
        if ((dec_saida != OK_STATE) && (dec_saida != ERR_STATE) && (sym_q != SYM_LAST)) begin
          sym_d = sym_q + SW'(1);
        end
      end
      SUCESSO: desbl_d = 1'b1;
      FALHA:   erro_d  = 1'b1;
      LIMPA: begin
        dreset_d = 1'b1;
        sym_d    = '0;
        tmo_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      tmo_q      <= '0;
      sym_q      <= '0;
      wait_q     <= '0;
      entrada_q  <= '0;
      controle_q <= 1'b0;
      dreset_q   <= 1'b0;
      desbl_q    <= 1'b0;
      erro_q     <= 1'b0;
      ativo_q    <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      sym_q      <= sym_d;
      wait_q     <= wait_d;
      entrada_q  <= entrada_d;
      controle_q <= controle_d;
      dreset_q   <= dreset_d;
      desbl_q    <= desbl_d;
      erro_q     <= erro_d;
      ativo_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sequenciador_decodificador.sv
// tb/tb_sequenciador_decodificador.sv - directed bench for sequenciador_decodificador
module tb_sequenciador_decodificador;
  import decodificador_pkg::*;

  localparam int T = 1000;

  logic       clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic [6:0] dec_entrada;
  logic       dec_controle;
  logic       dec_reset;
  logic [3:0] dec_saida;
  logic       desbloqueado;
  logic       erro;
  logic       ocupado;
  logic [2:0] fifo_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_desb = 0;
  int n_erro = 0;
  int base_desb;
  int base_erro;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (desbloqueado === 1'b1) n_desb++;
    if (erro === 1'b1) n_erro++;
  end

  sequenciador_decodificador dut (
    .clk          (clk),
    .Reset        (Reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dec_entrada  (dec_entrada),
    .dec_controle (dec_controle),
    .dec_reset    (dec_reset),
    .dec_saida    (dec_saida),
    .desbloqueado (desbloqueado),
    .erro         (erro),
    .ocupado      (ocupado),
    .fifo_count   (fifo_count)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_controle"}, 32'(dec_controle), 0);
    chk({tag, "_desbl"}, 32'(desbloqueado), 0);
    chk({tag, "_erro"}, 32'(erro), 0);
    chk({tag, "_ocupado"}, 32'(ocupado), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
  endtask

  initial begin
    Reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    dec_saida = 4'b0000;

    // reset and first LIMPA pulse
    tick(3);
    chk_quiet("rst");
    chk("rst_dec_reset", 32'(dec_reset), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_entrada", 32'(dec_entrada), 0);
    Reset = 1'b1;
    tick();
    chk("rel_dec_reset", 32'(dec_reset), 1);
    chk_quiet("rel");
    chk("rel_in_ready", 32'(in_ready), 1);
    tick();
    chk("rel_dec_reset_off", 32'(dec_reset), 0);

    // C1 then C6, decoder answers 0001 then 1001
    in_valid = 1'b1; in_data = C1; dec_saida = 4'b0001;
    tick();
    chk("ok_cnt1", 32'(fifo_count), 1);
    chk("ok_ctl_pre", 32'(dec_controle), 0);
    in_data = C6;
    tick();
    in_valid = 1'b0;
    chk("ok_ctl1", 32'(dec_controle), 1);
    chk("ok_ent1", 32'(dec_entrada), 32'(C1));
    chk("ok_cnt_pp", 32'(fifo_count), 1);
    chk("ok_busy", 32'(ocupado), 1);
    tick();
    chk("ok_ctl1_off", 32'(dec_controle), 0);
    tick(3);
    chk("ok_no_pulse1", 32'(desbloqueado | erro), 0);
    tick();
    chk("ok_ctl2", 32'(dec_controle), 1);
    chk("ok_ent2", 32'(dec_entrada), 32'(C6));
    dec_saida = 4'b1001;
    tick(5);
    chk("ok_desbl", 32'(desbloqueado), 1);
    chk("ok_desbl_dreset", 32'(dec_reset), 0);
    tick();
    chk("ok_desbl_off", 32'(desbloqueado), 0);
    chk("ok_dreset", 32'(dec_reset), 1);
    tick();
    chk("ok_dreset_off", 32'(dec_reset), 0);
    chk("ok_idle", 32'(ocupado), 0);

    // rejection with 3 symbols queued behind
    dec_saida = 4'b1000;
    in_valid = 1'b1; in_data = C1;
    tick();
    in_data = C2;
    tick();
    chk("err_ent", 32'(dec_entrada), 32'(C1));
    in_data = C3;
    tick();
    in_data = C4;
    tick();
    in_valid = 1'b0;
    chk("err_cnt3", 32'(fifo_count), 3);
    tick(2);
    chk("err_ready_falha", 32'(in_ready), 0);
    in_valid = 1'b1; in_data = C5;
    tick();
    in_valid = 1'b0;
    chk("err_pulse", 32'(erro), 1);
    chk("err_flush", 32'(fifo_count), 0);
    tick();
    chk("err_pulse_off", 32'(erro), 0);
    chk("err_dreset", 32'(dec_reset), 1);
    chk("err_cnt_after", 32'(fifo_count), 0);
    tick();

    // fill the FIFO while one symbol is in flight, then hit SEQ_LEN
    dec_saida = 4'b0001;
    in_valid = 1'b1; in_data = C2;
    tick();
    in_data = C3;
    tick();
    in_data = C4;
    tick();
    in_data = C5;
    tick();
    in_data = C6;
    tick();
    chk("full_cnt", 32'(fifo_count), 4);
    chk("full_ready", 32'(in_ready), 0);
    in_data = C1;
    tick();
    in_valid = 1'b0;
    chk("full_extra", 32'(fifo_count), 4);
    tick();
    chk("full_pop_cnt", 32'(fifo_count), 3);
    chk("full_pop_ready", 32'(in_ready), 1);
    chk("full_pop_ent", 32'(dec_entrada), 32'(C3));
    tick(14);
    chk("len_no_erro", 32'(erro), 0);
    chk("len_ent", 32'(dec_entrada), 32'(C5));
    tick();
    chk("len_erro", 32'(erro), 1);
    chk("len_flush", 32'(fifo_count), 0);
    tick();
    chk("len_dreset", 32'(dec_reset), 1);
    tick();

    // timeout after one accepted symbol
    in_valid = 1'b1; in_data = C1;
    tick();
    in_valid = 1'b0;
    tick(5);
    base_erro = n_erro;
    tick(T - 1);
    chk("tmo_early", 32'(n_erro - base_erro), 0);
    chk("tmo_busy", 32'(ocupado), 1);
    tick();
    chk("tmo_erro", 32'(erro), 1);
    tick();
    chk("tmo_erro_off", 32'(erro), 0);
    chk("tmo_dreset", 32'(dec_reset), 1);
    base_erro = n_erro;
    tick(T + 10);
    chk("tmo_none_idle", 32'(n_erro - base_erro), 0);
    chk("tmo_idle_busy", 32'(ocupado), 0);

    // reset during ESPERA with 2 symbols queued
    in_valid = 1'b1; in_data = C1;
    tick();
    in_data = C2;
    tick();
    in_data = C3;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_cnt2", 32'(fifo_count), 2);
    chk("ar_ent", 32'(dec_entrada), 32'(C1));
    base_desb = n_desb;
    base_erro = n_erro;
    #2;
    Reset = 1'b0;
    #1;
    chk_quiet("ar");
    chk("ar_entrada", 32'(dec_entrada), 0);
    chk("ar_in_ready", 32'(in_ready), 0);
    tick(2);
    Reset = 1'b1;
    tick();
    chk("ar_dreset", 32'(dec_reset), 1);
    chk("ar_cnt_rel", 32'(fifo_count), 0);
    tick(8);
    chk("ar_no_desbl", 32'(n_desb - base_desb), 0);
    chk("ar_no_erro", 32'(n_erro - base_erro), 0);
    chk("ar_idle", 32'(ocupado), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
